washing_controller: RTL and testbench

- Top-level sequencer for the washing machine. After a coin is accepted it runs one full programme: FILL, WASH, RINSE, SPIN, with an optional second WASH/RINSE round.
- Each phase is timed by an internal phase timer whose terminal count is derived from the selected clock-frequency code.
- Drives per-phase status outputs to the valve/motor logic and a sticky done flag to the user panel.

---
 rtl/washing_pkg.sv | 29 ++
 rtl/washing_controller_timer.sv | 28 ++
 rtl/washing_controller.sv | 150 +++++++++++++++
 tb/tb_washing_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/washing_pkg.sv
// Shared encodings and phase constants for the washing machine sequencer.
// Holds state codes, phase lengths in minutes and clock-frequency codes.
package washing_pkg;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = PH_IDLE,
    ST_FILL  = PH_FILL,
    ST_WASH  = PH_WASH,
    ST_RINSE = PH_RINSE,
    ST_SPIN  = PH_SPIN
  } state_e;

  localparam int unsigned FILL_MIN  = 2;
  localparam int unsigned WASH_MIN  = 5;
  localparam int unsigned RINSE_MIN = 2;
  localparam int unsigned SPIN_MIN  = 1;

  localparam logic [1:0] FREQ_1M = 2'b00;
  localparam logic [1:0] FREQ_2M = 2'b01;
  localparam logic [1:0] FREQ_4M = 2'b10;
  localparam logic [1:0] FREQ_8M = 2'b11;

endpackage

// File: rtl/washing_controller_timer.sv
// Phase timer: up-counter, done while count == terminal-1.
// Ports: clk, rst_n, clear, enable, terminal[CNT_W], done.
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == terminal - CNT_W'(1));

endmodule

// File: rtl/washing_controller.sv
// Washing machine sequencer: coin -> FILL, WASH, RINSE, [WASH, RINSE], SPIN.
// In: clk, rst_n, coin_in, double_wash, timer_pause, clk_freq[2]. Out: status, wash_done, phase[3].
module washing_controller
  import washing_pkg::*;
#(
  parameter int unsigned CYC_PER_MIN_F0 = 60_000_000,
  parameter int unsigned CYC_PER_MIN_F1 = 120_000_000,
  parameter int unsigned CYC_PER_MIN_F2 = 240_000_000,
  parameter int unsigned CYC_PER_MIN_F3 = 480_000_000,
  parameter int          CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  input  logic [1:0] clk_freq,
  output logic       filling,
  output logic       washing,
  output logic       rinsing,
  output logic       spinning,
  output logic       wash_done,
  output logic [2:0] phase
);

  state_e           state_q, state_n;
  logic [1:0]       freq_q, freq_n;
  logic             dbl_q, dbl_n;
  logic             round_q, round_n;
  logic             done_n;
  logic             fill_n, wash_n, rinse_n, spin_n;
  logic             tmr_clr, tmr_en, tmr_done;
  logic [CNT_W-1:0] cyc_min, terminal;

  always_comb begin
    cyc_min = CNT_W'(CYC_PER_MIN_F0);
    unique case (freq_q)
      FREQ_1M: cyc_min = CNT_W'(CYC_PER_MIN_F0);
      FREQ_2M: cyc_min = CNT_W'(CYC_PER_MIN_F1);
      FREQ_4M: cyc_min = CNT_W'(CYC_PER_MIN_F2);
      FREQ_8M: cyc_min = CNT_W'(CYC_PER_MIN_F3);
    endcase
    terminal = CNT_W'(1);
    case (state_q)
      ST_FILL:  terminal = cyc_min * CNT_W'(FILL_MIN);
      ST_WASH:  terminal = cyc_min * CNT_W'(WASH_MIN);
      ST_RINSE: terminal = cyc_min * CNT_W'(RINSE_MIN);
      ST_SPIN:  terminal = cyc_min * CNT_W'(SPIN_MIN);
      default:  terminal = CNT_W'(1);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clr),
    .enable   (tmr_en),
    .terminal (terminal),
    .done     (tmr_done)
  );

  always_comb begin
    state_n = state_q;
    freq_n  = freq_q;
    dbl_n   = dbl_q;
    round_n = round_q;
    done_n  = wash_done;
    tmr_clr = 1'b0;
    tmr_en  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (coin_in) begin
          state_n = ST_FILL;
          freq_n  = clk_freq;
          dbl_n   = double_wash;
          round_n = 1'b0;
          done_n  = 1'b0;
        end
      end
      ST_FILL: begin
        if (tmr_done) begin
          state_n = ST_WASH;
          tmr_clr = 1'b1;
        end
      end
      ST_WASH: begin
        if (tmr_done) begin
          state_n = ST_RINSE;
          tmr_clr = 1'b1;
        end
      end
      ST_RINSE: begin
        if (tmr_done) begin
          tmr_clr = 1'b1;
          if (dbl_q && !round_q) begin
            state_n = ST_WASH;
            round_n = 1'b1;
          end else begin
            state_n = ST_SPIN;
          end
        end
      end
      ST_SPIN: begin
        // Pause freezes the count and blocks completion.
        tmr_en = !timer_pause;
        if (tmr_done && !timer_pause) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    fill_n  = (state_n == ST_FILL);
    wash_n  = (state_n == ST_WASH);
    rinse_n = (state_n == ST_RINSE);
    spin_n  = (state_n == ST_SPIN) && !timer_pause;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      freq_q    <= '0;
      dbl_q     <= 1'b0;
      round_q   <= 1'b0;
      wash_done <= 1'b0;
      filling   <= 1'b0;
      washing   <= 1'b0;
      rinsing   <= 1'b0;
      spinning  <= 1'b0;
    end else begin
      state_q   <= state_n;
      freq_q    <= freq_n;
      dbl_q     <= dbl_n;
      round_q   <= round_n;
      wash_done <= done_n;
      filling   <= fill_n;
      washing   <= wash_n;
      rinsing   <= rinse_n;
      spinning  <= spin_n;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_washing_controller.sv
// Self-checking bench for washing_controller with scaled minute lengths.
// Expected per-cycle vectors are queued at coin time and popped each cycle.
module tb_washing_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic [1:0] clk_freq;
  logic       filling;
  logic       washing;
  logic       rinsing;
  logic       spinning;
  logic       wash_done;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  washing_controller #(
    .CYC_PER_MIN_F0 (4),
    .CYC_PER_MIN_F1 (8),
    .CYC_PER_MIN_F2 (16),
    .CYC_PER_MIN_F3 (32),
    .CNT_W          (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .double_wash (double_wash),
    .timer_pause (timer_pause),
    .clk_freq    (clk_freq),
    .filling     (filling),
    .washing     (washing),
    .rinsing     (rinsing),
    .spinning    (spinning),
    .wash_done   (wash_done),
    .phase       (phase)
  );

  function automatic logic [7:0] vec(logic [2:0] ph, logic sp,
                                     logic dn);
    return {ph, ph == 3'd1, ph == 3'd2, ph == 3'd3, sp, dn};
  endfunction

  function automatic void push_n(logic [2:0] ph, int n, logic sp,
                                 logic dn);
    for (int i = 0; i < n; i++) exp_q.push_back(vec(ph, sp, dn));
  endfunction

  function automatic bit paused(int j, int pa, int pl);
    return (j >= pa) && (j < pa + pl);
  endfunction

  // Runs one programme from a coin at edge E0. Cycle k is the state
  // after edge Ek; pause is applied on edges pa..pa+pl-1.
  task automatic run_prog(input logic [1:0] f, input logic dbl,
                          input int pa, input int pl, input bit hold,
                          input int stop, input int tail,
                          input string name);
    int cyc;
    int s;
    int cnt;
    int k;
    logic [7:0] got;
    logic [7:0] e;
    cyc = 4 << f;
    exp_q.delete();
    push_n(3'd1, 2 * cyc, 1'b0, 1'b0);
    push_n(3'd2, 5 * cyc, 1'b0, 1'b0);
    push_n(3'd3, 2 * cyc, 1'b0, 1'b0);
    if (dbl) begin
      push_n(3'd2, 5 * cyc, 1'b0, 1'b0);
      push_n(3'd3, 2 * cyc, 1'b0, 1'b0);
    end
    s = exp_q.size();
    push_n(3'd4, 1, !paused(s, pa, pl), 1'b0);
    cnt = 0;
    for (int j = s + 1; j < s + 1000; j++) begin
      if (paused(j, pa, pl)) begin
        push_n(3'd4, 1, 1'b0, 1'b0);
      end else if (cnt == cyc - 1) begin
        break;
      end else begin
        cnt++;
        push_n(3'd4, 1, 1'b1, 1'b0);
      end
    end
    if (hold) begin
      push_n(3'd0, 1, 1'b0, 1'b1);
      push_n(3'd1, 2, 1'b0, 1'b0);
    end else begin
      push_n(3'd0, tail, 1'b0, 1'b1);
    end
    @(negedge clk);
    coin_in     = 1'b1;
    clk_freq    = f;
    double_wash = dbl;
    timer_pause = paused(0, pa, pl);
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {phase, filling, washing, rinsing, spinning, wash_done};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b expected %b",
                 name, k, got, e);
      end
      if (k + 1 == stop) break;
      coin_in     = hold;
      timer_pause = paused(k + 1, pa, pl);
      if (hold) begin
        clk_freq    = ~f;
        double_wash = ~dbl;
      end
      k++;
    end
    coin_in     = 1'b0;
    timer_pause = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n       = 1'b0;
    coin_in     = 1'b0;
    double_wash = 1'b0;
    timer_pause = 1'b0;
    clk_freq    = 2'b00;
    repeat (3) @(negedge clk);
    got = {phase, filling, washing, rinsing, spinning, wash_done};
    n_vec++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL reset: got %b expected %b", got, 8'h00);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    test_reset();
    run_prog(2'b00, 1'b0, 0, 0, 1'b0, -1, 20, "single");
  endtask

  task automatic test_double();
    test_reset();
    run_prog(2'b00, 1'b1, 0, 0, 1'b0, -1, 4, "double");
  endtask

  task automatic test_freq3();
    test_reset();
    run_prog(2'b11, 1'b0, 0, 0, 1'b0, -1, 4, "freq3");
  endtask

  task automatic test_pause_spin();
    test_reset();
    run_prog(2'b00, 1'b0, 38, 10, 1'b0, -1, 4, "pause_spin");
  endtask

  task automatic test_pause_ignored();
    test_reset();
    run_prog(2'b00, 1'b0, 2, 20, 1'b0, -1, 4, "pause_ign");
  endtask

  task automatic test_noise_hold();
    test_reset();
    run_prog(2'b00, 1'b0, 0, 0, 1'b1, -1, 0, "coin_hold");
  endtask

  task automatic test_back_to_back();
    test_reset();
    run_prog(2'b01, 1'b0, 0, 0, 1'b0, -1, 3, "b2b_first");
    run_prog(2'b00, 1'b1, 0, 0, 1'b0, -1, 3, "b2b_second");
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    test_reset();
    run_prog(2'b00, 1'b0, 0, 0, 1'b0, 30, 0, "pre_abort");
    #2;
    rst_n = 1'b0;
    #1;
    got = {phase, filling, washing, rinsing, spinning, wash_done};
    n_vec++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL abort: got %b expected %b", got, 8'h00);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(2'b00, 1'b0, 0, 0, 1'b0, -1, 2, "post_abort");
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_freq3();
    test_pause_spin();
    test_pause_ignored();
    test_noise_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
